// File: rtl/serial_rx_pkg.sv
// Shared state encoding and line-level constants for the framed serial receiver.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sipo_shifter.sv
// Right-shift SIPO register: each enabled edge pushes serialIn into the MSB,
// so after WIDTH LSB-first bits the word sits in natural order.
module sipo_shifter #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             shiftEn,
    input  logic             serialIn,
    output logic [WIDTH-1:0] parOut
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_q <= '0;
        else if (shiftEn)
            r_q <= {serialIn, r_q[WIDTH-1:1]};
    end

    assign parOut = r_q;

endmodule

// File: rtl/serial_word_rx.sv
// Framed serial word receiver: start / WIDTH data bits LSB first / optional even
// parity / stop, sampled on sampleEn, delivered as a word plus one-cycle pulses.
module serial_word_rx
    import serial_rx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             serialIn,
    input  logic             sampleEn,
    output logic [WIDTH-1:0] Out,
    output logic             outValid,
    output logic             parityErr,
    output logic             frameErr,
    output logic             busy
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    rx_state_t        r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_par;
    logic [WIDTH-1:0] w_word;
    logic             w_shift_en;

    assign w_shift_en = sampleEn && (r_state == DATA);

    sipo_shifter #(.WIDTH(WIDTH)) u_shift (
        .Clk      (Clk),
        .Reset    (Reset),
        .shiftEn  (w_shift_en),
        .serialIn (serialIn),
        .parOut   (w_word)
    );

    // r_par folds in data bits and the received parity bit; nonzero at stop = parity error
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_par     <= 1'b0;
            Out       <= '0;
            outValid  <= 1'b0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            outValid  <= 1'b0;
            parityErr <= 1'b0;
            frameErr  <= 1'b0;
            if (sampleEn) begin
                case (r_state)
                    IDLE: begin
                        if (serialIn == START_BIT) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                            r_par   <= 1'b0;
                        end
                    end
                    DATA: begin
                        r_par <= r_par ^ serialIn;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            if (PARITY_EN != 0)
                                r_state <= PARITY;
                            else
                                r_state <= STOP;
                        end
                    end
                    PARITY: begin
                        r_par   <= r_par ^ serialIn;
                        r_state <= STOP;
                    end
                    STOP: begin
                        if (serialIn == STOP_BIT) begin
                            Out       <= w_word;
                            outValid  <= 1'b1;
                            parityErr <= (PARITY_EN != 0) && r_par;
                            r_state   <= IDLE;
                        end else begin
                            frameErr  <= 1'b1;
                            r_state   <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (serialIn == IDLE_LEVEL)
                            r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_serial_word_rx.sv
// Randomized + directed bench for serial_word_rx; expectations come from a
// frame-level model (word, parity flip, stop level) rather than state tracking.
module tb_serial_word_rx;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       serialIn = 1'b1;
    logic       sampleEn = 1'b1;
    logic [3:0] Out;
    logic       outValid, parityErr, frameErr, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_valid = 0;
    int t_prev  = 0;
    logic [3:0] exp_out = 4'h0;

    serial_word_rx #(.WIDTH(4), .PARITY_EN(1)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .serialIn  (serialIn),
        .sampleEn  (sampleEn),
        .Out       (Out),
        .outValid  (outValid),
        .parityErr (parityErr),
        .frameErr  (frameErr),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp_v, cyc);
        end
    endtask

    // gap disabled edges (line randomized), then one enabled edge carrying b
    task automatic send_bit(input logic b, input int gap, input bit is_stop);
        for (int g = 0; g < gap; g++) begin
            sampleEn = 1'b0;
            serialIn = 1'($urandom);
            @(posedge Clk); #1;
            chk("quiet_gap", {outValid, parityErr, frameErr}, 0);
        end
        sampleEn = 1'b1;
        serialIn = b;
        @(posedge Clk); #1;
        if (!is_stop) chk("quiet", {outValid, parityErr, frameErr}, 0);
        sampleEn = 1'b1;
        serialIn = 1'b1;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic pflip, input logic stop_lvl, input int gap);
        send_bit(1'b0, gap, 1'b0);
        chk("busy_start", busy, 1);
        for (int i = 0; i < 4; i++) send_bit(d[i], gap, 1'b0);
        send_bit((^d) ^ pflip, gap, 1'b0);
        send_bit(stop_lvl, gap, 1'b1);
        if (stop_lvl) begin
            exp_out = d;
            t_prev  = t_valid;
            t_valid = cyc;
            chk("pulses_ok", {outValid, parityErr, frameErr}, {1'b1, pflip, 1'b0});
            chk("busy_done", busy, 0);
        end else begin
            chk("pulses_ferr", {outValid, parityErr, frameErr}, 3'b001);
            chk("busy_wait", busy, 1);
        end
        chk("out", Out, exp_out);
    endtask

    task automatic idle_ones(input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(1'b1, 0, 1'b0);
            chk("busy_idle", busy, 0);
        end
    endtask

    initial begin
        // reset
        Reset = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        chk("reset_outs", {Out, outValid, parityErr, frameErr, busy}, 0);
        Reset = 1'b0;
        idle_ones(5);

        // good frame, then parity error
        send_frame(4'b1001, 1'b0, 1'b1, 0);
        @(posedge Clk); #1;
        chk("one_cycle", {outValid, parityErr, frameErr}, 0);
        send_frame(4'b1001, 1'b1, 1'b1, 0);

        // frame error, line stuck low, recover, then 0110
        send_frame(4'b1101, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b0, 0, 1'b0);
            chk("busy_stuck", busy, 1);
        end
        send_bit(1'b1, 0, 1'b0);
        chk("busy_recover", busy, 0);
        send_frame(4'b0110, 1'b0, 1'b1, 0);

        // strobe every third cycle
        send_frame(4'b1001, 1'b0, 1'b1, 2);

        // reset after two data bits
        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        Reset = 1'b1;
        #1;
        chk("reset_mid", {Out, outValid, parityErr, frameErr, busy}, 0);
        exp_out = 4'h0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        send_frame(4'b1101, 1'b0, 1'b1, 0);

        // back-to-back frames
        send_frame(4'b1001, 1'b0, 1'b1, 0);
        send_frame(4'b0110, 1'b0, 1'b1, 0);
        chk("b2b_spacing", t_valid - t_prev, 7);

        // random frames
        for (int k = 0; k < 60; k++) begin
            logic [3:0] d;
            logic       pf, st;
            int         gap;
            d   = 4'($urandom);
            pf  = ($urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(0, 2);
            send_frame(d, pf, st, gap);
            if (!st) begin
                int z = $urandom_range(0, 3);
                for (int i = 0; i < z; i++) begin
                    send_bit(1'b0, gap, 1'b0);
                    chk("rnd_busy_stuck", busy, 1);
                end
                send_bit(1'b1, gap, 1'b0);
                chk("rnd_busy_recover", busy, 0);
            end
            idle_ones($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-in, parallel-out framed word receiver. It is the receiving end of the serial link that our universal shift register drives in shift mode. It samples one bit per enabled clock from a single line, recognises start/data/parity/stop framing, and presents each received word on a parallel bus with a one-cycle valid pulse. It sits between the serial line and any parallel consumer, and reuses the universal shift register's `Clk`/`Reset` conventions.

## Interface
- `WIDTH`, 4: data bits per frame; must be ≥ 2.
- `PARITY_EN`, 1: 1 means an even-parity bit follows the data; 0 means no parity bit.

Ports:
- `Clk`  in  1  the only clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state immediately.
- `serialIn`  in  1  serial line; idles high.
- `sampleEn`  in  1  bit strobe; `serialIn` is sampled only on edges where this is 1.
- `Out`  out  WIDTH  last accepted word.
- `outValid`  out  1  one-cycle pulse when `Out` has just been updated.
- `parityErr`  out  1  one-cycle pulse, coincident with `outValid`, when the parity check failed.
- `frameErr`  out  1  one-cycle pulse when the stop bit was sampled as 0.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).

## Operation
- Frame format: start bit 0, then WIDTH data bits LSB first, then the parity bit (only if `PARITY_EN`), then stop bit 1.
- FSM states: IDLE, DATA, PARITY, STOP, WAIT_IDLE. Every transition requires `sampleEn`=1.
  - IDLE → DATA when `serialIn`=0. This sample is the start bit. The bit counter clears to 0.
  - DATA: shift `serialIn` into the MSB of the shift register (right shift). Increment the counter.
    - After the WIDTH-th data bit: go to PARITY if `PARITY_EN`, otherwise go to STOP.
  - PARITY: capture `serialIn` as the received parity bit. Go to STOP.
  - STOP, `serialIn`=1: load `Out` with the shift register and pulse `outValid`. Pulse `parityErr` if the XOR of the data bits and the parity bit is 1. Go to IDLE.
  - STOP, `serialIn`=0: pulse `frameErr`. `Out` is unchanged and `outValid` stays 0. Go to WAIT_IDLE.
  - WAIT_IDLE → IDLE when `serialIn`=1.
- A parity-errored word is still delivered: `Out` updates and `outValid` is 1, with `parityErr` also 1.
- `outValid`, `parityErr` and `frameErr` are never high together with each other except the `outValid` + `parityErr` pair.
- Edges with `sampleEn`=0 hold all state. The pulse outputs return to 0 on the next edge regardless of `sampleEn`.
- `serialIn`=1 in IDLE is ignored.

## Timing
- Reset values: `Out`=0, `outValid`=0, `parityErr`=0, `frameErr`=0, `busy`=0. FSM = IDLE, counter = 0, shift register = 0.
- A frame takes WIDTH+PARITY_EN+2 enabled samples.
- `outValid` or `frameErr` is high for the single cycle after the edge that samples the stop bit. There is no further latency.
- `busy` rises in the cycle after the start-bit sample. It falls in the cycle after the stop sample on a good frame, or after the line-high sample in WAIT_IDLE.
- A start bit may be sampled on the enabled edge immediately after a good stop bit, so back-to-back frames are supported.
- `Reset` asserted mid-frame: outputs go to their reset values at once and the partial word is discarded. After `Reset` deasserts, reception starts again from IDLE.

## Structure
- Package `serial_rx_pkg` holds:
  - the FSM state enum;
  - the `START_BIT`=0, `STOP_BIT`=1 and `IDLE_LEVEL`=1 constants.
- Sub-module `sipo_shifter`: a WIDTH-bit right-shift register with `shiftEn`, `serialIn` and a parallel output. It is cleared by `Reset`. The FSM, the counter, the parity accumulator and the output registers stay in `serial_word_rx`.

## Test plan
With WIDTH=4, PARITY_EN=1 and `sampleEn` tied to 1 unless stated otherwise:
- Reset behaviour: assert `Reset` for 10 cycles → all outputs are 0 and `busy` is 0. Then hold `serialIn`=1 for 5 cycles → no pulses.
- Good frame: send 0,1,0,0,1,0,1 (start, data 1001 LSB first, parity 0, stop) → `Out`=4'b1001 and `outValid`=1 for exactly one cycle. `parityErr`=0.
- Parity error: same frame as above but with parity bit 1 → `Out`=4'b1001, with `outValid` and `parityErr` both pulsed in the same cycle.
- Frame error: send data 1101 (bits 1,0,1,1), parity 1, stop 0 → `frameErr` pulses and `Out` keeps its previous value. Then hold `serialIn`=0 for 3 cycles → `busy` stays 1. After `serialIn`=1, a following good frame carrying 0110 is received correctly.
- Strobe gating: send the good 1001 frame with `sampleEn` high on every third cycle only → same result as the good-frame case, with `outValid` on the cycle after the 7th enabled edge.
- Reset mid-frame: assert `Reset` after two data bits, then release it and send the good 1101 frame → `Out`=4'b1101 with no stale bits from the aborted frame. Also send two back-to-back frames, 1001 and 0110 → two `outValid` pulses 7 cycles apart.
